irq_priority_ctrl: RTL and testbench
====================================

IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the number of interrupt channels (2..32).
REQ-002 The block SHALL have parameter CW, default 3, meaning the channel index width (clog2(N)).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, active-low, synchronous
REQ-004 The block SHALL have these ports:
- request  in  N  level-sensitive interrupt requests
- mask  in  N  per-channel mask, 1 = masked
- sm  in  1  special mask mode
- rot_en  in  1  rotate priority on EOI
- eoi_ns  in  1  non-specific EOI pulse
- eoi_sp  in  1  specific EOI pulse
- eoi_lvl  in  CW  channel targeted by eoi_sp
- set_pri  in  1  pulse that loads the lowest-priority channel
- pri_lvl  in  CW  value loaded by set_pri
- inta  in  1  acknowledge pulse from CPU
- intr  out  1  interrupt to CPU
- code  out  CW  acknowledged channel index
- code_vld  out  1  code valid strobe
- spurious  out  1  acknowledge had no winner
- isr  out  N  in-service register

Function
REQ-005 Requests SHALL be qualified as nmr = request & ~mask, evaluated every cycle.
REQ-006 A CW-bit register lp SHALL hold the lowest-priority channel; the rank of channel i SHALL be (i - lp - 1) mod N, with rank 0 highest.
REQ-007 The winner SHALL be the set nmr bit with the lowest rank; the highest in-service channel SHALL be the set isr bit with the lowest rank.
REQ-008 The winner SHALL be eligible when sm=1 and nmr!=0, or when sm=0 and the winner's rank is strictly below the highest in-service rank (or isr=0).
REQ-009 The FSM SHALL have three states:
- IDLE: goes to PEND when a winner is eligible.
- PEND: intr=1; goes to ACK on inta.
- ACK: code_vld=1 for exactly one cycle, then returns to IDLE.
REQ-010 Latency SHALL be one cycle from an eligible winner to intr=1, and one cycle from inta to code_vld=1.
REQ-011 On inta in PEND, the winner SHALL be re-evaluated and its index registered into code, and its isr bit SHALL be set.
REQ-012 If there is no eligible winner on inta (the request dropped), code SHALL be N-1, spurious=1 with code_vld, and isr SHALL be unchanged.
REQ-013 If the winner becomes ineligible in PEND without inta, intr SHALL stay 1 until inta.
REQ-014 eoi_ns SHALL clear the highest in-service isr bit; when isr=0 it SHALL have no effect.
REQ-015 eoi_sp SHALL clear isr[eoi_lvl].
REQ-016 When rot_en=1, any EOI that clears a bit SHALL load lp with the index of that bit.
REQ-017 set_pri SHALL load lp with pri_lvl, and SHALL take precedence over an EOI rotation in the same cycle.
REQ-018 When eoi_ns and eoi_sp arrive in the same cycle, eoi_sp SHALL win.
REQ-019 When an isr set and an EOI clear hit the same bit in the same cycle, the set SHALL win.
REQ-020 eoi_lvl and pri_lvl values of N or greater SHALL be ignored.
REQ-021 intr SHALL be 0 in IDLE and ACK.

Reset
REQ-022 When rst_n=0 at a clk edge, the FSM SHALL go to IDLE, lp SHALL be N-1 (channel 0 highest), and intr, code, code_vld, spurious and isr SHALL all be 0.
REQ-023 Reset SHALL abort an acknowledge in progress; no isr bit SHALL be set for it.

Configuration
REQ-024 With IRQ_PRIORITY_CTRL_AEOI_EN defined, the isr bit set by an acknowledge SHALL clear automatically in the cycle after ACK, applying rotation per REQ-016 if rot_en=1.
REQ-025 Without IRQ_PRIORITY_CTRL_AEOI_EN, isr bits SHALL clear only via eoi_ns or eoi_sp.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- N=8, after reset, request=0x0A -> intr next cycle; inta -> code=1, code_vld pulse, isr=0x02.
- isr=0x02, sm=0, request=0x08 -> intr stays 0; sm=1 -> intr=1, inta -> code=3, isr=0x0A.
- rot_en=1, isr=0x04, eoi_ns -> isr=0, lp=2; request=0x06 -> inta gives code=1 (rank of 2 is now lowest).
- set_pri with pri_lvl=4, request=0x21 -> inta gives code=5.
- request=0x10, intr=1, request drops before inta -> code=7, spurious=1, isr unchanged.
- rst_n low during ACK -> all outputs 0, lp=7; with IRQ_PRIORITY_CTRL_AEOI_EN, an inta on channel 2 -> isr bit 2 set during ACK, cleared the next cycle.

Source files
------------

// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: rotating-priority interrupt controller with an in-service
// register, special mask mode, specific/non-specific EOI and spurious detection.
// Optional feature: define IRQ_PRIORITY_CTRL_AEOI_EN for automatic EOI, where the
// in-service bit set by an acknowledge clears in the cycle after ACK.
module irq_priority_ctrl #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  request,
  input  logic [N-1:0]  mask,
  input  logic          sm,
  input  logic          rot_en,
  input  logic          eoi_ns,
  input  logic          eoi_sp,
  input  logic [CW-1:0] eoi_lvl,
  input  logic          set_pri,
  input  logic [CW-1:0] pri_lvl,
  input  logic          inta,
  output logic          intr,
  output logic [CW-1:0] code,
  output logic          code_vld,
  output logic          spurious,
  output logic [N-1:0]  isr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] lp_q, lp_d;
  logic [N-1:0]  isr_q, isr_d;
  logic [CW-1:0] code_q, code_d;
  logic          intr_q, intr_d;
  logic          code_vld_q, code_vld_d;
  logic          spurious_q, spurious_d;

  logic [N-1:0]  nmr_c;
  logic          win_vld_c;
  logic [CW-1:0] win_ch_c;
  logic [CW-1:0] win_rank_c;
  logic          his_vld_c;
  logic [CW-1:0] his_ch_c;
  logic [CW-1:0] his_rank_c;
  logic          eligible_c;
  logic          eoi_sp_ok_c;
  logic          pri_ok_c;
  logic [N-1:0]  set_c;
  logic [N-1:0]  clr_c;
  logic          rot_vld_c;
  logic [CW-1:0] rot_ch_c;

  // Channel holding rank r when lp_v is the lowest-priority channel.
  function automatic logic [CW-1:0] rank_to_ch(input logic [CW-1:0] lp_v,
                                                input int unsigned r);
    int unsigned t;
    t = 32'(lp_v) + 32'd1 + r;
    if (t >= N) t = t - N;
    return CW'(t);
  endfunction

  assign nmr_c       = request & ~mask;
  assign eoi_sp_ok_c = eoi_sp && (32'(eoi_lvl) < N);
  assign pri_ok_c    = set_pri && (32'(pri_lvl) < N);

  // Scan ranks from highest priority down to find the winner and top in-service channel.
  always_comb begin
    win_vld_c  = 1'b0;
    win_ch_c   = '0;
    win_rank_c = '0;
    his_vld_c  = 1'b0;
    his_ch_c   = '0;
    his_rank_c = '0;
    for (int unsigned r = 0; r < N; r++) begin
      if (!win_vld_c && nmr_c[rank_to_ch(lp_q, r)]) begin
        win_vld_c  = 1'b1;
        win_ch_c   = rank_to_ch(lp_q, r);
        win_rank_c = CW'(r);
      end
      if (!his_vld_c && isr_q[rank_to_ch(lp_q, r)]) begin
        his_vld_c  = 1'b1;
        his_ch_c   = rank_to_ch(lp_q, r);
        his_rank_c = CW'(r);
      end
    end
  end

  // Winner may interrupt if special mask is on, or it outranks everything in service.
  assign eligible_c = win_vld_c && (sm || !his_vld_c || (win_rank_c < his_rank_c));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (eligible_c) state_d = ST_PEND;
      ST_PEND: if (inta) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values: acknowledge capture, EOI clears, priority rotation.
  always_comb begin
    intr_d     = (state_d == ST_PEND);
    code_vld_d = 1'b0;
    spurious_d = 1'b0;
    code_d     = code_q;
    set_c      = '0;
    clr_c      = '0;
    rot_vld_c  = 1'b0;
    rot_ch_c   = '0;
    lp_d       = lp_q;

    if (state_q == ST_PEND && inta) begin
      code_vld_d = 1'b1;
      if (eligible_c) begin
        code_d = win_ch_c;
        set_c  = N'(1) << win_ch_c;
      end else begin
        code_d     = CW'(N - 1);
        spurious_d = 1'b1;
      end
    end

`ifdef IRQ_PRIORITY_CTRL_AEOI_EN
    if (state_q == ST_ACK && !spurious_q && isr_q[code_q]) begin
      clr_c     = clr_c | (N'(1) << code_q);
      rot_vld_c = 1'b1;
      rot_ch_c  = code_q;
    end
`endif

    // A specific EOI suppresses a simultaneous non-specific one.
    if (eoi_sp_ok_c) begin
      if (isr_q[eoi_lvl]) begin
        clr_c     = clr_c | (N'(1) << eoi_lvl);
        rot_vld_c = 1'b1;
        rot_ch_c  = eoi_lvl;
      end
    end else if (eoi_ns && his_vld_c) begin
      clr_c     = clr_c | (N'(1) << his_ch_c);
      rot_vld_c = 1'b1;
      rot_ch_c  = his_ch_c;
    end

    // A new acknowledge wins over a clear of the same bit.
    isr_d = (isr_q & ~clr_c) | set_c;

    // Explicit priority load overrides EOI rotation.
    if (rot_en && rot_vld_c) lp_d = rot_ch_c;
    if (pri_ok_c) lp_d = pri_lvl;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lp_q       <= CW'(N - 1);
      isr_q      <= '0;
      code_q     <= '0;
      intr_q     <= 1'b0;
      code_vld_q <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      lp_q       <= lp_d;
      isr_q      <= isr_d;
      code_q     <= code_d;
      intr_q     <= intr_d;
      code_vld_q <= code_vld_d;
      spurious_q <= spurious_d;
    end
  end

  assign intr     = intr_q;
  assign code     = code_q;
  assign code_vld = code_vld_q;
  assign spurious = spurious_q;
  assign isr      = isr_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed bench for irq_priority_ctrl (N=8). Honours IRQ_PRIORITY_CTRL_AEOI_EN.
module tb_irq_priority_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  request;
  logic [N-1:0]  mask;
  logic          sm;
  logic          rot_en;
  logic          eoi_ns;
  logic          eoi_sp;
  logic [CW-1:0] eoi_lvl;
  logic          set_pri;
  logic [CW-1:0] pri_lvl;
  logic          inta;
  logic          intr;
  logic [CW-1:0] code;
  logic          code_vld;
  logic          spurious;
  logic [N-1:0]  isr;

  int total = 0;
  int bad   = 0;

  irq_priority_ctrl #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .mask(mask), .sm(sm),
    .rot_en(rot_en), .eoi_ns(eoi_ns), .eoi_sp(eoi_sp), .eoi_lvl(eoi_lvl),
    .set_pri(set_pri), .pri_lvl(pri_lvl), .inta(inta), .intr(intr),
    .code(code), .code_vld(code_vld), .spurious(spurious), .isr(isr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; request = '0; mask = '0; sm = 1'b0; rot_en = 1'b0;
    eoi_ns = 1'b0; eoi_sp = 1'b0; eoi_lvl = '0; set_pri = 1'b0; pri_lvl = '0;
    inta = 1'b0;
    tick(); tick();
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL rst_intr got=%0h exp=0", intr); end
    total++; if (code !== 3'd0) begin bad++; $display("FAIL rst_code got=%0h exp=0", code); end
    total++; if (code_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%0h exp=0", code_vld); end
    total++; if (spurious !== 1'b0) begin bad++; $display("FAIL rst_spur got=%0h exp=0", spurious); end
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL rst_isr got=%0h exp=0", isr); end
    total++; if (dut.lp_q !== 3'd7) begin bad++; $display("FAIL rst_lp got=%0d exp=7", dut.lp_q); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_ack();
    request = 8'h0A;
    tick();
    total++; if (intr !== 1'b1) begin bad++; $display("FAIL basic_intr got=%0h exp=1", intr); end
    total++; if (code_vld !== 1'b0) begin bad++; $display("FAIL basic_vld_early got=%0h exp=0", code_vld); end
    inta = 1'b1;
    tick();
    inta = 1'b0;
    total++; if (code_vld !== 1'b1) begin bad++; $display("FAIL basic_vld got=%0h exp=1", code_vld); end
    total++; if (code !== 3'd1) begin bad++; $display("FAIL basic_code got=%0d exp=1", code); end
    total++; if (isr !== 8'h02) begin bad++; $display("FAIL basic_isr got=%0h exp=02", isr); end
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL basic_intr_ack got=%0h exp=0", intr); end
    tick();
    total++; if (code_vld !== 1'b0) begin bad++; $display("FAIL basic_vld_pulse got=%0h exp=0", code_vld); end
    request = '0;
    tick();
  endtask

  task automatic test_special_mask();
    request = 8'h08; sm = 1'b0;
    tick(); tick();
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL sm0_blocked got=%0h exp=0", intr); end
    sm = 1'b1;
    tick();
    total++; if (intr !== 1'b1) begin bad++; $display("FAIL sm1_intr got=%0h exp=1", intr); end
    inta = 1'b1;
    tick();
    inta = 1'b0; request = '0; sm = 1'b0;
    total++; if (code !== 3'd3) begin bad++; $display("FAIL sm1_code got=%0d exp=3", code); end
    total++; if (isr !== 8'h0A) begin bad++; $display("FAIL sm1_isr got=%0h exp=0a", isr); end
    tick();
    eoi_ns = 1'b1; eoi_sp = 1'b1; eoi_lvl = 3'd3;
    tick();
    eoi_ns = 1'b0; eoi_sp = 1'b0;
    total++; if (isr !== 8'h02) begin bad++; $display("FAIL eoi_sp_wins got=%0h exp=02", isr); end
    eoi_ns = 1'b1;
    tick();
    eoi_ns = 1'b0;
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL eoi_ns_clr got=%0h exp=0", isr); end
    total++; if (dut.lp_q !== 3'd7) begin bad++; $display("FAIL norot_lp got=%0d exp=7", dut.lp_q); end
  endtask

  task automatic test_rotation();
    request = 8'h04;
    tick();
    inta = 1'b1;
    tick();
    inta = 1'b0; request = '0;
    total++; if (isr !== 8'h04) begin bad++; $display("FAIL rot_setup_isr got=%0h exp=04", isr); end
    tick();
    rot_en = 1'b1; eoi_ns = 1'b1;
    tick();
    rot_en = 1'b0; eoi_ns = 1'b0;
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL rot_isr got=%0h exp=0", isr); end
    total++; if (dut.lp_q !== 3'd2) begin bad++; $display("FAIL rot_lp got=%0d exp=2", dut.lp_q); end
    request = 8'h06;
    tick();
    total++; if (intr !== 1'b1) begin bad++; $display("FAIL rot_intr got=%0h exp=1", intr); end
    inta = 1'b1;
    tick();
    inta = 1'b0; request = '0;
    total++; if (code !== 3'd1) begin bad++; $display("FAIL rot_code got=%0d exp=1", code); end
    tick();
    eoi_ns = 1'b1;
    tick();
    eoi_ns = 1'b0;
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL rot_cleanup got=%0h exp=0", isr); end
  endtask

  task automatic test_set_pri();
    set_pri = 1'b1; pri_lvl = 3'd4;
    tick();
    set_pri = 1'b0;
    total++; if (dut.lp_q !== 3'd4) begin bad++; $display("FAIL setpri_lp got=%0d exp=4", dut.lp_q); end
    request = 8'h21;
    tick();
    inta = 1'b1; eoi_sp = 1'b1; eoi_lvl = 3'd5;
    tick();
    inta = 1'b0; eoi_sp = 1'b0; request = '0;
    total++; if (code !== 3'd5) begin bad++; $display("FAIL setpri_code got=%0d exp=5", code); end
    total++; if (isr !== 8'h20) begin bad++; $display("FAIL set_beats_clr got=%0h exp=20", isr); end
    tick();
    rot_en = 1'b1; eoi_ns = 1'b1; set_pri = 1'b1; pri_lvl = 3'd7;
    tick();
    rot_en = 1'b0; eoi_ns = 1'b0; set_pri = 1'b0;
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL prec_isr got=%0h exp=0", isr); end
    total++; if (dut.lp_q !== 3'd7) begin bad++; $display("FAIL setpri_over_rot got=%0d exp=7", dut.lp_q); end
  endtask

  task automatic test_spurious();
    request = 8'h10;
    tick();
    total++; if (intr !== 1'b1) begin bad++; $display("FAIL spur_intr got=%0h exp=1", intr); end
    request = '0;
    tick();
    total++; if (intr !== 1'b1) begin bad++; $display("FAIL spur_hold got=%0h exp=1", intr); end
    inta = 1'b1;
    tick();
    inta = 1'b0;
    total++; if (code_vld !== 1'b1) begin bad++; $display("FAIL spur_vld got=%0h exp=1", code_vld); end
    total++; if (code !== 3'd7) begin bad++; $display("FAIL spur_code got=%0d exp=7", code); end
    total++; if (spurious !== 1'b1) begin bad++; $display("FAIL spur_flag got=%0h exp=1", spurious); end
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL spur_isr got=%0h exp=0", isr); end
    tick();
    total++; if (spurious !== 1'b0) begin bad++; $display("FAIL spur_pulse got=%0h exp=0", spurious); end
  endtask

  task automatic test_reset_abort();
    set_pri = 1'b1; pri_lvl = 3'd4;
    tick();
    set_pri = 1'b0;
    request = 8'h04;
    tick();
    inta = 1'b1; rst_n = 1'b0;
    tick();
    inta = 1'b0;
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL abort_isr got=%0h exp=0", isr); end
    total++; if (code_vld !== 1'b0) begin bad++; $display("FAIL abort_vld got=%0h exp=0", code_vld); end
    rst_n = 1'b1;
    tick();
    total++; if (intr !== 1'b1) begin bad++; $display("FAIL abort_reintr got=%0h exp=1", intr); end
    inta = 1'b1;
    tick();
    inta = 1'b0;
    total++; if (isr !== 8'h04) begin bad++; $display("FAIL abort_ack_isr got=%0h exp=04", isr); end
    rst_n = 1'b0; request = '0;
    tick();
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL ackrst_intr got=%0h exp=0", intr); end
    total++; if (code !== 3'd0) begin bad++; $display("FAIL ackrst_code got=%0d exp=0", code); end
    total++; if (code_vld !== 1'b0) begin bad++; $display("FAIL ackrst_vld got=%0h exp=0", code_vld); end
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL ackrst_isr got=%0h exp=0", isr); end
    total++; if (dut.lp_q !== 3'd7) begin bad++; $display("FAIL ackrst_lp got=%0d exp=7", dut.lp_q); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_aeoi();
    request = 8'h04;
    tick();
    inta = 1'b1;
    tick();
    inta = 1'b0; request = '0;
    total++; if (isr !== 8'h04) begin bad++; $display("FAIL aeoi_ack_isr got=%0h exp=04", isr); end
    tick();
`ifdef IRQ_PRIORITY_CTRL_AEOI_EN
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL aeoi_clear got=%0h exp=0", isr); end
`else
    total++; if (isr !== 8'h04) begin bad++; $display("FAIL no_aeoi_hold got=%0h exp=04", isr); end
    eoi_ns = 1'b1;
    tick();
    eoi_ns = 1'b0;
`endif
    rot_en = 1'b1; request = 8'h02;
    tick();
    inta = 1'b1;
    tick();
    inta = 1'b0; request = '0;
    tick();
    rot_en = 1'b0;
`ifdef IRQ_PRIORITY_CTRL_AEOI_EN
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL aeoi_rot_isr got=%0h exp=0", isr); end
    total++; if (dut.lp_q !== 3'd1) begin bad++; $display("FAIL aeoi_rot_lp got=%0d exp=1", dut.lp_q); end
`else
    total++; if (isr !== 8'h02) begin bad++; $display("FAIL no_aeoi_isr got=%0h exp=02", isr); end
    total++; if (dut.lp_q !== 3'd7) begin bad++; $display("FAIL no_aeoi_lp got=%0d exp=7", dut.lp_q); end
`endif
  endtask

  initial begin
    test_reset();
`ifndef IRQ_PRIORITY_CTRL_AEOI_EN
    test_basic_ack();
    test_special_mask();
    test_rotation();
    test_set_pri();
`endif
    test_spurious();
    test_reset_abort();
    test_aeoi();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
